// File: rtl/prach_hb1_sched_if.sv
// Handshake bundle between the PRACH HB1 scheduler and its surroundings.
// frame_cnt exists only when PRACH_HB1_SCHED_STATUS_EN is defined.
interface prach_hb1_sched_if #(parameter int NUM_CHN = 8);
  logic               enable;
  logic [NUM_CHN-1:0] chn_mask;
  logic               sync_in;
  logic               sync_err_clr;
  logic               rd_en;
  logic [7:0]         rd_chn;
  logic               hb_dv;
  logic [7:0]         hb_chn;
  logic               hb_sync;
  logic               busy;
  logic               sync_err;
`ifdef PRACH_HB1_SCHED_STATUS_EN
  logic [15:0]        frame_cnt;
`endif

  modport master (
    output enable, chn_mask, sync_in, sync_err_clr,
    input  rd_en, rd_chn, hb_dv, hb_chn, hb_sync, busy, sync_err
`ifdef PRACH_HB1_SCHED_STATUS_EN
    , input frame_cnt
`endif
  );

  modport slave (
    input  enable, chn_mask, sync_in, sync_err_clr,
    output rd_en, rd_chn, hb_dv, hb_chn, hb_sync, busy, sync_err
`ifdef PRACH_HB1_SCHED_STATUS_EN
    , output frame_cnt
`endif
  );
endinterface

// File: rtl/prach_hb1_sched.sv
// TDM slot scheduler feeding the PRACH HB1 datapath, frames aligned to sync_in.
// Optional completed-frame counter enabled by PRACH_HB1_SCHED_STATUS_EN.
module prach_hb1_sched #(
  parameter int NUM_CHN     = 8,
  parameter int SLOT_CYCLES = 2
) (
  input logic              clk,
  input logic              rst_n,
  prach_hb1_sched_if.slave bus
);
  localparam int SW = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;
  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_CHN - 1);
  localparam logic [CW-1:0] LAST_CYC  = CW'(SLOT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DRAIN} state_t;

  state_t             r_state, w_next;
  logic [SW-1:0]      r_slot;
  logic [CW-1:0]      r_cyc;
  logic [NUM_CHN-1:0] r_mask;
  logic               r_hb_dv, r_hb_sync, r_sync_err;
  logic [7:0]         r_hb_chn;
  logic               w_busy, w_last, w_start, w_abort, w_rd_en;
  logic [7:0]         w_rd_chn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.enable) w_next = S_ARMED;
      S_ARMED: begin
        if (!bus.enable)      w_next = S_IDLE;
        else if (bus.sync_in) w_next = S_RUN;
      end
      S_RUN: begin
        if (!bus.enable) w_next = w_last ? S_IDLE : S_DRAIN;
        else if (w_last) w_next = bus.sync_in ? S_RUN : S_ARMED;
      end
      S_DRAIN: if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // A sync in RUN restarts the frame whether it lands on the last cycle (back-to-back) or not (abort).
  always_comb begin
    w_busy   = (r_state == S_RUN) || (r_state == S_DRAIN);
    w_last   = w_busy && (r_slot == LAST_SLOT) && (r_cyc == LAST_CYC);
    w_start  = bus.sync_in && bus.enable && ((r_state == S_ARMED) || (r_state == S_RUN));
    w_abort  = (r_state == S_RUN) && bus.sync_in && bus.enable && !w_last;
    w_rd_en  = w_busy && (r_cyc == '0) && r_mask[r_slot];
    w_rd_chn = w_rd_en ? 8'(r_slot) : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= '0;
      r_cyc  <= '0;
      r_mask <= '0;
    end else if (w_start) begin
      r_slot <= '0;
      r_cyc  <= '0;
      r_mask <= bus.chn_mask;
    end else if (w_busy) begin
      if (r_cyc == LAST_CYC) begin
        r_cyc  <= '0;
        r_slot <= (r_slot == LAST_SLOT) ? '0 : r_slot + SW'(1);
      end else begin
        r_cyc  <= r_cyc + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hb_dv    <= 1'b0;
      r_hb_chn   <= 8'd0;
      r_hb_sync  <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_hb_dv   <= w_rd_en;
      if (w_rd_en) r_hb_chn <= w_rd_chn;
      r_hb_sync <= w_busy && (r_slot == '0) && (r_cyc == '0);
      if (w_abort)               r_sync_err <= 1'b1;
      else if (bus.sync_err_clr) r_sync_err <= 1'b0;
    end
  end

`ifdef PRACH_HB1_SCHED_STATUS_EN
  logic [15:0] r_frame_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_frame_cnt <= 16'd0;
    else if (w_last) r_frame_cnt <= r_frame_cnt + 16'd1;
  end
  assign bus.frame_cnt = r_frame_cnt;
`endif

  assign bus.rd_en    = w_rd_en;
  assign bus.rd_chn   = w_rd_chn;
  assign bus.hb_dv    = r_hb_dv;
  assign bus.hb_chn   = r_hb_chn;
  assign bus.hb_sync  = r_hb_sync;
  assign bus.busy     = w_busy;
  assign bus.sync_err = r_sync_err;
endmodule

// File: tb/tb_prach_hb1_sched.sv
// Bench for prach_hb1_sched: directed frame scenarios then random traffic,
// every cycle compared against a frame-position model.
module tb_prach_hb1_sched;
  localparam int NC = 4;
  localparam int SC = 2;
  localparam int FL = NC * SC;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prach_hb1_sched_if #(.NUM_CHN(NC)) bus();
  prach_hb1_sched #(.NUM_CHN(NC), .SLOT_CYCLES(SC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  // model: phase 0 idle, 1 waiting for sync, 2 frame running, 3 finishing after enable drop
  int          m_ph;
  int          m_pos;
  logic [NC-1:0] m_mask;
  logic        m_hdv, m_hsync, m_err;
  logic [7:0]  m_hchn;
  int          m_fcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_pos = 0; m_mask = '0;
    m_hdv = 0; m_hsync = 0; m_err = 0; m_hchn = 8'd0; m_fcnt = 0;
  endtask

  task automatic check_all();
    bit busy, rd;
    busy = (m_ph >= 2);
    rd   = busy && (m_pos % SC == 0) && m_mask[m_pos / SC];
    chk("busy", 32'(bus.busy), 32'(busy));
    chk("rd_en", 32'(bus.rd_en), 32'(rd));
    if (rd) chk("rd_chn", 32'(bus.rd_chn), 32'(m_pos / SC));
    chk("hb_dv", 32'(bus.hb_dv), 32'(m_hdv));
    chk("hb_chn", 32'(bus.hb_chn), 32'(m_hchn));
    chk("hb_sync", 32'(bus.hb_sync), 32'(m_hsync));
    chk("sync_err", 32'(bus.sync_err), 32'(m_err));
`ifdef PRACH_HB1_SCHED_STATUS_EN
    chk("frame_cnt", 32'(bus.frame_cnt), 32'(m_fcnt));
`endif
  endtask

  task automatic model_upd(input bit en, input bit sy, input logic [NC-1:0] m, input bit clr);
    bit busy, last, rd, start, abort;
    busy  = (m_ph >= 2);
    last  = busy && (m_pos == FL - 1);
    rd    = busy && (m_pos % SC == 0) && m_mask[m_pos / SC];
    start = en && sy && (m_ph == 1 || m_ph == 2);
    abort = (m_ph == 2) && en && sy && !last;
    m_hdv = rd;
    if (rd) m_hchn = 8'(m_pos / SC);
    m_hsync = busy && (m_pos == 0);
    if (abort)    m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    if (last) m_fcnt = (m_fcnt + 1) % 65536;
    case (m_ph)
      0: if (en) m_ph = 1;
      1: if (!en) m_ph = 0; else if (sy) m_ph = 2;
      2: if (!en) m_ph = last ? 0 : 3; else if (last) m_ph = sy ? 2 : 1;
      default: if (last) m_ph = 0;
    endcase
    m_pos = start ? 0 : (busy ? (last ? 0 : m_pos + 1) : 0);
    if (start) m_mask = m;
  endtask

  task automatic step(input bit en, input bit sy, input logic [NC-1:0] m, input bit clr);
    check_all();
    bus.enable = en; bus.sync_in = sy; bus.chn_mask = m; bus.sync_err_clr = clr;
    model_upd(en, sy, m, clr);
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_rd_en"}, 32'(bus.rd_en), 32'd0);
    chk({tag, "_rd_chn"}, 32'(bus.rd_chn), 32'd0);
    chk({tag, "_hb_dv"}, 32'(bus.hb_dv), 32'd0);
    chk({tag, "_hb_chn"}, 32'(bus.hb_chn), 32'd0);
    chk({tag, "_hb_sync"}, 32'(bus.hb_sync), 32'd0);
    chk({tag, "_sync_err"}, 32'(bus.sync_err), 32'd0);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.enable = 0; bus.sync_in = 0; bus.chn_mask = '0; bus.sync_err_clr = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // full mask frame, then idle back in ARMED
    step(1, 0, 4'hF, 0);
    step(1, 1, 4'hF, 0);
    repeat (10) step(1, 0, 4'hF, 0);

    // sparse mask keeps slot timing
    step(1, 1, 4'b0101, 0);
    repeat (10) step(1, 0, 4'hF, 0);

    // back-to-back frames, mask re-latched for the second
    step(1, 1, 4'hF, 0);
    repeat (7) step(1, 0, 4'h0, 0);
    step(1, 1, 4'b1010, 0);
    repeat (9) step(1, 0, 4'h0, 0);
    chk("b2b_no_err", 32'(bus.sync_err), 32'd0);

    // misaligned sync aborts and restarts, sticky error then clear
    step(1, 1, 4'hF, 0);
    repeat (3) step(1, 0, 4'h0, 0);
    step(1, 1, 4'b0111, 0);
    chk("err_set", 32'(bus.sync_err), 32'd1);
    chk("restart_rd_chn", 32'(bus.rd_chn), 32'd0);
    repeat (14) step(1, 0, 4'h0, 0);
    step(1, 0, 4'h0, 1);
    chk("err_clr", 32'(bus.sync_err), 32'd0);

    // enable drop drains the frame; sync during drain ignored
    step(1, 1, 4'hF, 0);
    repeat (2) step(1, 0, 4'h0, 0);
    repeat (3) step(0, 0, 4'h0, 0);
    step(0, 1, 4'hF, 0);
    repeat (2) step(0, 0, 4'h0, 0);
    chk("drain_done", 32'(bus.busy), 32'd0);
    repeat (2) step(0, 0, 4'h0, 0);

    // reset mid-frame, then no reads until a fresh sync
    step(1, 0, 4'hF, 0);
    step(1, 1, 4'hF, 0);
    repeat (4) step(1, 0, 4'hF, 0);
    mid_reset();
    repeat (12) step(1, 0, 4'hF, 0);
    step(1, 1, 4'hF, 0);
    repeat (9) step(1, 0, 4'hF, 0);

    // random traffic including simultaneous set/clear of sync_err
    for (int i = 0; i < 3000; i++) begin
      bit en, sy, clr;
      logic [NC-1:0] m;
      en  = ($urandom_range(0, 15) != 0);
      sy  = ($urandom_range(0, 6) == 0);
      clr = ($urandom_range(0, 7) == 0);
      m   = NC'($urandom);
      if ($urandom_range(0, 299) == 0) mid_reset();
      step(en, sy, m, clr);
    end
    check_all();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/prach_hb1_sched.md
PRACH_HB1_SCHED -- requirements
Module: prach_hb1_sched

Interface
REQ-001 Parameter NUM_CHN, default 8, number of TDM channels sharing the HB1 datapath (1..256).
REQ-002 Parameter SLOT_CYCLES, default 2, clock cycles per channel slot (>=1).
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  level; scheduler permitted to run frames.
REQ-006 chn_mask  input  NUM_CHN  per-channel enable; bit i gates channel i.
REQ-007 sync_in  input  1  single-cycle frame-start strobe from the upstream timing source.
REQ-008 sync_err_clr  input  1  single-cycle clear of sync_err.
REQ-009 rd_en  output  1  read strobe to the upstream sample buffer (1-cycle read latency).
REQ-010 rd_chn  output  8  channel index accompanying rd_en.
REQ-011 hb_dv  output  1  drives HB1 din_dv.
REQ-012 hb_chn  output  8  drives HB1 din_chn.
REQ-013 hb_sync  output  1  drives HB1 sync_in.
REQ-014 busy  output  1  high in RUN or DRAIN.
REQ-015 sync_err  output  1  sticky misaligned-sync flag.

Function
REQ-016 FSM states IDLE, ARMED, RUN, DRAIN; reset state IDLE.
REQ-017 IDLE -> ARMED when enable=1; ARMED -> IDLE when enable=0.
REQ-018 ARMED -> RUN on sync_in=1; frame begins the cycle after sync_in; chn_mask latched in the sync_in cycle.
REQ-019 Frame = NUM_CHN slots x SLOT_CYCLES cycles, channels 0..NUM_CHN-1 in ascending order; masked channels keep their slot time (no skipping).
REQ-020 rd_en=1 and rd_chn=slot channel on the first cycle of each slot whose latched mask bit is 1; otherwise rd_en=0.
REQ-021 hb_dv/hb_chn equal rd_en/rd_chn delayed exactly 1 cycle; hb_chn holds last value when hb_dv=0.
REQ-022 hb_sync pulses 1 cycle, 1 cycle after the first cycle of slot 0 of every frame, regardless of chn_mask[0].
REQ-023 Last frame cycle with sync_in=1 and enable=1: back-to-back frame, no gap, mask re-latched.
REQ-024 Last frame cycle without sync_in: -> ARMED if enable=1, else -> IDLE.
REQ-025 sync_in in RUN on any cycle other than the last: sync_err set; frame aborted and restarted at slot 0 the next cycle with mask re-latched.
REQ-026 enable falling during RUN: -> DRAIN; current frame completes unchanged; sync_in ignored in DRAIN; then -> IDLE.
REQ-027 sync_err_clr clears sync_err; simultaneous set and clear: set wins.
REQ-028 Slot and channel counters wrap to 0 at frame end; no arithmetic overflow for NUM_CHN=256.

Reset
REQ-029 rst_n=0 asynchronously forces IDLE and clears counters and mask register.
REQ-030 Reset values: rd_en=0, rd_chn=0, hb_dv=0, hb_chn=0, hb_sync=0, busy=0, sync_err=0 (frame_cnt=0 when present).
REQ-031 Reset mid-frame abandons the frame; after release the scheduler waits for a new sync_in via ARMED.

Configuration
REQ-032 Macro PRACH_HB1_SCHED_STATUS_EN defined: extra output frame_cnt (16 bit) increments at each completed frame (wrapping at 65535->0) and aborted frames are not counted.
REQ-033 Macro undefined: frame_cnt port and its logic absent; all other behaviour identical.

Verification (NUM_CHN=4, SLOT_CYCLES=2)
REQ-034 enable=1, mask=4'b1111, sync_in at t0 -> rd_en at t0+1,+3,+5,+7 with rd_chn 0,1,2,3; hb_dv one cycle later; hb_sync at t0+2; busy high t0+1..t0+8.
REQ-035 mask=4'b0101 -> rd_en only at t0+1 (chn 0) and t0+5 (chn 2); frame still 8 cycles; hb_sync at t0+2.
REQ-036 sync_in at t0 and t0+8 -> second frame starts t0+9 with no gap; hb_sync at t0+2 and t0+10; sync_err stays 0.
REQ-037 sync_in at t0 and t0+4 -> sync_err=1 from t0+5; restart rd_chn=0 at t0+5; sync_err_clr at t0+20 -> 0.
REQ-038 enable=0 at t0+3 -> frame completes through t0+8; sync_in at t0+6 ignored; IDLE, busy=0 from t0+9.
REQ-039 rst_n=0 at t0+4 -> all outputs 0 immediately; after release, no rd_en until next sync_in with enable=1.
